// File: rtl/multi_deque_if.sv
// -----------------------------------------------------------------------------
// multi_deque_if
// Shared command/data bus of the multi-channel deque store.
//   ch_sel   : channel addressed this cycle
//   end_sel  : 0 = front end, 1 = back end
//   push/pop : operation strobes (both high = replace / pass-through)
//   data_in  : word to push
//   data_out : last popped word (registered)
//   empty    : per-channel empty flags (registered)
//   full     : per-channel full flags (registered)
//   count    : occupancy of the channel on ch_sel (combinational)
//   err      : one-cycle pulse after a rejected operation
// master = user side driving commands, slave = the deque block.
// -----------------------------------------------------------------------------
interface multi_deque_if #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 12,
  parameter int CHANNELS = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) ();
  logic [CH_W-1:0]     ch_sel;
  logic                end_sel;
  logic                push;
  logic                pop;
  logic [WIDTH-1:0]    data_in;
  logic [WIDTH-1:0]    data_out;
  logic [CHANNELS-1:0] empty;
  logic [CHANNELS-1:0] full;
  logic [CNT_W-1:0]    count;
  logic                err;

  modport master (
    output ch_sel, end_sel, push, pop, data_in,
    input  data_out, empty, full, count, err
  );

  modport slave (
    input  ch_sel, end_sel, push, pop, data_in,
    output data_out, empty, full, count, err
  );
endinterface

// File: rtl/multi_deque.sv
// -----------------------------------------------------------------------------
// multi_deque
// CHANNELS independent double-ended queues of DEPTH x WIDTH words behind one
// shared push/pop port. Each channel is a circular buffer with a head pointer
// (front word), a tail pointer (first free slot after the back word) and an
// occupancy counter, so DEPTH need not be a power of two.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (clears pointers, counters, flags)
//   bus : multi_deque_if slave modport (see interface header)
// -----------------------------------------------------------------------------
module multi_deque #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 12,
  parameter int CHANNELS = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          rst,
  multi_deque_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] OCC_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] OCC_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(DEPTH);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

  // Explicit modulo-DEPTH wrap in both directions.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? PTR_ZERO : (p + PTR_ONE);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == PTR_ZERO) ? PTR_LAST : (p - PTR_ONE);
  endfunction

  logic [WIDTH-1:0]    mem_q  [CHANNELS][DEPTH];
  logic [PTR_W-1:0]    head_q [CHANNELS];
  logic [PTR_W-1:0]    head_d [CHANNELS];
  logic [PTR_W-1:0]    tail_q [CHANNELS];
  logic [PTR_W-1:0]    tail_d [CHANNELS];
  logic [CNT_W-1:0]    occ_q  [CHANNELS];
  logic [CNT_W-1:0]    occ_d  [CHANNELS];
  logic [WIDTH-1:0]    data_out_q, data_out_d;
  logic                err_q, err_d;
  logic [CHANNELS-1:0] empty_q, empty_d;
  logic [CHANNELS-1:0] full_q, full_d;

  logic                sel_valid_s;
  logic [CH_W-1:0]     ch_idx_s;
  logic [PTR_W-1:0]    cur_head_s, cur_tail_s;
  logic [CNT_W-1:0]    cur_occ_s;
  logic [PTR_W-1:0]    head_m1_s, head_p1_s, tail_m1_s, tail_p1_s;
  logic [PTR_W-1:0]    end_addr_s;
  logic                wr_en_s;
  logic [PTR_W-1:0]    wr_addr_s;

  // Out-of-range selects are steered to channel 0 for reads only; every
  // operation on them is rejected below, so channel 0 is never modified.
  assign sel_valid_s = ({1'b0, bus.ch_sel} < CH_LIMIT);
  assign ch_idx_s    = sel_valid_s ? bus.ch_sel : {CH_W{1'b0}};
  assign cur_head_s  = head_q[ch_idx_s];
  assign cur_tail_s  = tail_q[ch_idx_s];
  assign cur_occ_s   = occ_q[ch_idx_s];
  assign head_m1_s   = ptr_dec(cur_head_s);
  assign head_p1_s   = ptr_inc(cur_head_s);
  assign tail_m1_s   = ptr_dec(cur_tail_s);
  assign tail_p1_s   = ptr_inc(cur_tail_s);
  // Slot holding the word at the selected end (front word or last back word).
  assign end_addr_s  = bus.end_sel ? tail_m1_s : cur_head_s;

  // Next-state decode for the single channel addressed this cycle.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    data_out_d = data_out_q;
    err_d      = 1'b0;
    wr_en_s    = 1'b0;
    wr_addr_s  = end_addr_s;
    if (!(bus.push || bus.pop)) begin
      err_d = 1'b0;
    end else if (!sel_valid_s) begin
      err_d = 1'b1;
    end else if (bus.push && bus.pop) begin
      // Replace the end word; on an empty channel the word just passes through.
      if (cur_occ_s == OCC_ZERO) begin
        data_out_d = bus.data_in;
      end else begin
        data_out_d = mem_q[ch_idx_s][end_addr_s];
        wr_en_s    = 1'b1;
        wr_addr_s  = end_addr_s;
      end
    end else if (bus.push) begin
      if (cur_occ_s == OCC_FULL) begin
        err_d = 1'b1;
      end else begin
        wr_en_s          = 1'b1;
        occ_d[ch_idx_s]  = cur_occ_s + OCC_ONE;
        if (bus.end_sel) begin
          wr_addr_s        = cur_tail_s;
          tail_d[ch_idx_s] = tail_p1_s;
        end else begin
          wr_addr_s        = head_m1_s;
          head_d[ch_idx_s] = head_m1_s;
        end
      end
    end else begin
      if (cur_occ_s == OCC_ZERO) begin
        err_d = 1'b1;
      end else begin
        data_out_d      = mem_q[ch_idx_s][end_addr_s];
        occ_d[ch_idx_s] = cur_occ_s - OCC_ONE;
        if (bus.end_sel) begin
          tail_d[ch_idx_s] = tail_m1_s;
        end else begin
          head_d[ch_idx_s] = head_p1_s;
        end
      end
    end
  end

  // Flags are derived from next-state occupancy so they register with it.
  always_comb begin
    empty_d = {CHANNELS{1'b0}};
    full_d  = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      empty_d[i] = (occ_d[i] == OCC_ZERO);
      full_d[i]  = (occ_d[i] == OCC_FULL);
    end
  end

  // Control state: pointers, occupancies, flags, output word and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '{default: PTR_ZERO};
      tail_q     <= '{default: PTR_ZERO};
      occ_q      <= '{default: OCC_ZERO};
      data_out_q <= {WIDTH{1'b0}};
      err_q      <= 1'b0;
      empty_q    <= {CHANNELS{1'b1}};
      full_q     <= {CHANNELS{1'b0}};
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
    end
  end

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[ch_idx_s][wr_addr_s] <= bus.data_in;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.err      = err_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = sel_valid_s ? cur_occ_s : OCC_ZERO;
endmodule
